// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full adder, a carry flop and LSB-first shift
// registers. It produces a WIDTH-bit sum plus carry-out on a valid/ready port.
module full_adder (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = in1 ^ in2 ^ cin;
  assign cout = (in1 & in2) | (cin & (in1 ^ in2));

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CNT_W-1:0] bit_cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_next;

  full_adder u_fa (
    .in1  (a_sh[0]),
    .in2  (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Each new sum bit enters at the MSB, so after WIDTH shifts bit 0 lands at res_sum[0].
  if (WIDTH == 1) begin : g_one
    assign sum_next = fa_sum;
  end else begin : g_multi
    assign sum_next = {fa_sum, res_sum[WIDTH-1:1]};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      bit_cnt   <= '0;
      carry     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= op_a;
            b_sh     <= op_b;
            carry    <= cin;
            bit_cnt  <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          res_sum <= sum_next;
          carry   <= fa_cout;
          bit_cnt <= bit_cnt + CNT_W'(1);
          // The MSB pair is being added on this edge; its carry is the final carry-out.
          if (bit_cnt == CNT_W'(WIDTH - 1)) begin
            state     <= DONE;
            res_cout  <= fa_cout;
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed and random adds at WIDTH=8,
// plus random-only runs at WIDTH=1 and WIDTH=32 on their own instances.
module tb_serial_add_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       cin;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_sum;
  logic       res_cout;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int extra_done = 0;

  logic [8:0] exp_q[$];
  int         lat_q[$];
  logic       prev_valid = 1'b0;
  logic       stall_en = 1'b0;
  logic       stall_bit = 1'b1;
  logic       rr_val = 1'b1;

  assign res_ready = stall_en ? stall_bit : rr_val;

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    stall_bit <= 1'($urandom_range(0, 1));
  end

  serial_add_ctrl #(.WIDTH(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Holds in_valid until the DUT takes the operands, then records what it owes us.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic c, input logic [8:0] expected);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    cin = c;
    for (int k = 0; k < 200 && !acc; k++) begin
      acc = in_ready;
      @(posedge sys_clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
    else begin
      exp_q.push_back(expected);
      lat_q.push_back(cyc);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && (exp_q.size() != 0 || busy); k++) begin
      @(posedge sys_clk);
      #1;
    end
    checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (res_valid && !prev_valid) begin
        if (lat_q.size() == 0) checkOutput("unexpected_valid", 64'd1, 64'd0);
        else checkOutput("latency", 64'(cyc - lat_q[0]), 64'd8);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) checkOutput("unexpected_result", {res_cout, res_sum}, 64'd0);
        else begin
          checkOutput("result", {res_cout, res_sum}, exp_q.pop_front());
          void'(lat_q.pop_front());
        end
      end
    end
    prev_valid = res_valid;
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    sys_rst = 1'b1;
    in_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    cin = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_res_sum", res_sum, 0);
    checkOutput("rst_res_cout", res_cout, 0);

    applyStimulus(8'h5A, 8'h3C, 1'b0, 9'h096);
    applyStimulus(8'hFF, 8'h01, 1'b0, 9'h100);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    applyStimulus(8'h00, 8'h00, 1'b1, 9'h001);
    drain();

    // Backpressure: the result must sit still while in_valid pulses are ignored.
    rr_val = 1'b0;
    applyStimulus(8'h81, 8'h80, 1'b1, 9'h102);
    for (int k = 0; k < 50 && !res_valid; k++) begin
      @(posedge sys_clk);
      #1;
    end
    checkOutput("bp_valid_seen", res_valid, 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      op_a = 8'($urandom);
      op_b = 8'($urandom);
      cin = 1'b1;
      checkOutput("bp_res_valid", res_valid, 1);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_busy", busy, 1);
      checkOutput("bp_stable", {res_cout, res_sum}, 9'h102);
      @(posedge sys_clk);
      #1;
    end
    in_valid = 1'b0;
    rr_val = 1'b1;
    @(posedge sys_clk);
    #1;
    checkOutput("bp_release_valid", res_valid, 0);
    checkOutput("bp_release_in_ready", in_ready, 1);
    drain();

    // Abort an add on its 4th RUN cycle; nothing is queued for it.
    checkOutput("abort_idle", in_ready, 1);
    in_valid = 1'b1;
    op_a = 8'hAB;
    op_b = 8'hCD;
    cin = 1'b1;
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge sys_clk);
      #1;
    end
    checkOutput("abort_busy_before", busy, 1);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_res_valid", res_valid, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_res_sum", res_sum, 0);
    repeat (10) @(posedge sys_clk);
    #1;
    checkOutput("abort_no_valid", res_valid, 0);
    applyStimulus(8'h12, 8'h34, 1'b0, 9'h046);
    drain();

    stall_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 9'(rc));
    end
    drain();
    stall_en = 1'b0;

    for (int k = 0; k < 80000 && extra_done < 2; k++) @(posedge sys_clk);
    checkOutput("extra_widths_done", 64'(extra_done), 64'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Random-only runs at the width extremes, each with its own reset and scoreboard.
  for (genvar g = 0; g < 2; g++) begin : g_x
    localparam int W = (g == 0) ? 1 : 32;

    logic         x_rst;
    logic         x_in_valid;
    logic         x_in_ready;
    logic [W-1:0] x_op_a;
    logic [W-1:0] x_op_b;
    logic         x_cin;
    logic         x_res_valid;
    logic         x_res_ready;
    logic [W-1:0] x_res_sum;
    logic         x_res_cout;
    logic         x_busy;
    logic [W:0]   x_exp_q[$];
    int           x_lat_q[$];
    logic         x_prev_valid = 1'b0;

    always @(posedge sys_clk) x_res_ready <= 1'($urandom_range(0, 1));

    serial_add_ctrl #(.WIDTH(W)) dut_x (
      .sys_clk   (sys_clk),
      .sys_rst   (x_rst),
      .in_valid  (x_in_valid),
      .in_ready  (x_in_ready),
      .op_a      (x_op_a),
      .op_b      (x_op_b),
      .cin       (x_cin),
      .res_valid (x_res_valid),
      .res_ready (x_res_ready),
      .res_sum   (x_res_sum),
      .res_cout  (x_res_cout),
      .busy      (x_busy)
    );

    always @(negedge sys_clk) begin
      if (!x_rst) begin
        if (x_res_valid && !x_prev_valid) begin
          if (x_lat_q.size() == 0) checkOutput($sformatf("w%0d_unexpected_valid", W), 64'd1, 64'd0);
          else checkOutput($sformatf("w%0d_latency", W), 64'(cyc - x_lat_q[0]), 64'(W));
        end
        if (x_res_valid && x_res_ready) begin
          if (x_exp_q.size() == 0) checkOutput($sformatf("w%0d_unexpected_result", W), 64'd1, 64'd0);
          else begin
            checkOutput($sformatf("w%0d_result", W), 64'({x_res_cout, x_res_sum}), 64'(x_exp_q.pop_front()));
            void'(x_lat_q.pop_front());
          end
        end
      end
      x_prev_valid = x_res_valid;
    end

    initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      logic         acc;
      x_rst = 1'b1;
      x_in_valid = 1'b0;
      x_op_a = '0;
      x_op_b = '0;
      x_cin = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      x_rst = 1'b0;
      checkOutput($sformatf("w%0d_rst_in_ready", W), x_in_ready, 1);
      checkOutput($sformatf("w%0d_rst_res_valid", W), x_res_valid, 0);
      for (int i = 0; i < 1000; i++) begin
        a = W'($urandom);
        b = W'($urandom);
        c = 1'($urandom_range(0, 1));
        x_in_valid = 1'b1;
        x_op_a = a;
        x_op_b = b;
        x_cin = c;
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) begin
          acc = x_in_ready;
          @(posedge sys_clk);
          #1;
        end
        x_in_valid = 1'b0;
        if (!acc) checkOutput($sformatf("w%0d_accept_timeout", W), 64'd0, 64'd1);
        else begin
          x_exp_q.push_back({1'b0, a} + {1'b0, b} + (W + 1)'(c));
          x_lat_q.push_back(cyc);
        end
      end
      for (int k = 0; k < 500 && (x_exp_q.size() != 0 || x_busy); k++) begin
        @(posedge sys_clk);
        #1;
      end
      checkOutput($sformatf("w%0d_drain_pending", W), 64'(x_exp_q.size()), 64'd0);
      extra_done++;
    end
  end

endmodule
